// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: data width, register index width, register count, x0 index.
package riscv_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-writer tracking and operand stall generation.
// Build option: REGFILE_BYPASS_EN lets a same-cycle writeback resolve a source hazard.
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NREG = NUM_REGS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  output logic                  stall_o,
  output logic [NREG-1:0]       busy_mask_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            byp1, byp2;
  logic            hz1, hz2;
  logic            issue_acc;

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    byp1 = wb_en_i && (wb_rd_i == rs1_addr_i);
    byp2 = wb_en_i && (wb_rd_i == rs2_addr_i);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    hz1     = (rs1_addr_i != X0_IDX) && busy_q[rs1_addr_i] && !byp1;
    hz2     = (rs2_addr_i != X0_IDX) && busy_q[rs2_addr_i] && !byp2;
    stall_o = hz1 || hz2;
  end

  assign issue_acc = issue_valid_i && !stall_o && (issue_rd_i != X0_IDX);

  // Clear first, then set: a reservation taken in the writeback cycle keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) busy_d[wb_rd_i] = 1'b0;
    if (issue_acc) busy_d[issue_rd_i] = 1'b1;
    busy_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_mask_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with hardwired x0, plus scoreboard for RAW hazard stalls.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module reg_file_sb
  import riscv_pkg::*;
#(
  parameter int unsigned N    = XLEN,
  parameter int unsigned NREG = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [N-1:0]          rs1_data,
  output logic [N-1:0]          rs2_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [N-1:0]          wb_data,
  output logic                  stall,
  output logic [NREG-1:0]       busy_mask
);

  logic [N-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_rd != X0_IDX)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
    if (rs1_addr == X0_IDX) rs1_data = '0;
    if (rs2_addr == X0_IDX) rs2_data = '0;
  end

  reg_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk_i        (clk),
    .rst_i        (rst),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .wb_en_i      (wb_en),
    .wb_rd_i      (wb_rd),
    .stall_o      (stall),
    .busy_mask_o  (busy_mask)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios plus randomized traffic vs a register model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst, issue_valid, wb_en, stall;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, wb_data, busy_mask;

  reg_file_sb #(.N(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] rs1, rs2, mask;
    logic        stl;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          cur_stall;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input int a);
    return (a != 0) && m_busy[a] && !(BYP && wb_en && (int'(wb_rd) == a));
  endfunction

  function automatic logic [31:0] read_model(input int a);
    if (a == 0) return 32'h0;
    if (BYP && wb_en && (int'(wb_rd) == a)) return wb_data;
    return m_reg[a];
  endfunction

  task automatic drive(input bit r, input bit iv, input int ird, input bit we, input int wrd,
                       input logic [31:0] wd, input int a1, input int a2);
    exp_t e;
    rst = r; issue_valid = iv; issue_rd = 5'(ird); wb_en = we; wb_rd = 5'(wrd);
    wb_data = wd; rs1_addr = 5'(a1); rs2_addr = 5'(a2);
    e.chk = !r;
    e.stl = hazard(a1) || hazard(a2);
    e.rs1 = read_model(a1);
    e.rs2 = read_model(a2);
    for (int i = 0; i < 32; i++) e.mask[i] = m_busy[i];
    cur_stall = e.stl;
    q.push_back(e);
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 1'b0; end
    end else begin
      if (wb_en && wb_rd != 0) m_reg[wb_rd] = wb_data;
      if (wb_en) m_busy[wb_rd] = 1'b0;
      if (issue_valid && !cur_stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic cycle(input bit r, input bit iv, input int ird, input bit we, input int wrd,
                       input logic [31:0] wd, input int a1, input int a2);
    drive(r, iv, ird, we, wrd, wd, a1, a2);
    step();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        check_val("rs1_data", rs1_data, e.rs1);
        check_val("rs2_data", rs2_data, e.rs2);
        check_val("stall", {31'h0, stall}, {31'h0, e.stl});
        check_val("busy_mask", busy_mask, e.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 1'b0; end
    cur_stall = 1'b0;
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    step();

    // Reset state
    drive(0, 0, 0, 0, 0, 32'h0, 5, 9);
    @(negedge clk);
    check_val("reset_stall", {31'h0, stall}, 32'h0);
    check_val("reset_rs1", rs1_data, 32'h0);
    check_val("reset_mask", busy_mask, 32'h0);
    step();

    // Basic write then read
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 5, 0);
    @(negedge clk); check_val("wr_rd_x5", rs1_data, 32'hDEADBEEF);
    step();

    // x0 protection
    cycle(0, 1, 0, 1, 0, 32'h12345678, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check_val("x0_read", rs2_data, 32'h0);
    check_val("x0_busy", busy_mask, 32'h0);
    step();

    // RAW hazard on x7
    cycle(0, 1, 7, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 7, 0);
    @(negedge clk); check_val("hz_stall", {31'h0, stall}, 32'h1);
    step();
    drive(0, 0, 0, 1, 7, 32'hA5A5A5A5, 7, 0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check_val("hz_byp_stall", {31'h0, stall}, 32'h0);
    check_val("hz_byp_data", rs1_data, 32'hA5A5A5A5);
`else
    check_val("hz_wb_stall", {31'h0, stall}, 32'h1);
`endif
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 7, 0);
    @(negedge clk);
    check_val("hz_after_stall", {31'h0, stall}, 32'h0);
    check_val("hz_after_data", rs1_data, 32'hA5A5A5A5);
    step();

    // Same-cycle issue and writeback to x3
    cycle(0, 1, 3, 1, 3, 32'h33333333, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 3, 0);
    @(negedge clk);
    check_val("simul_busy3", (busy_mask >> 3) & 32'h1, 32'h1);
    check_val("simul_x3", rs1_data, 32'h33333333);
    step();
    cycle(0, 0, 0, 1, 3, 32'h33333333, 0, 0);

    // Issue blocked while stalled
    cycle(0, 1, 4, 0, 0, 32'h0, 0, 0);
    drive(0, 1, 9, 0, 0, 32'h0, 4, 0);
    @(negedge clk); check_val("blk_stall", {31'h0, stall}, 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); check_val("blk_busy9", (busy_mask >> 9) & 32'h1, 32'h0);
    step();
    cycle(0, 0, 0, 1, 4, 32'h44444444, 0, 0);

    // Mid-operation reset during a writeback
    cycle(0, 1, 7, 0, 0, 32'h0, 0, 0);
    cycle(0, 1, 10, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); check_val("pre_rst_mask", busy_mask, 32'h00000480);
    step();
    cycle(1, 0, 0, 1, 12, 32'hCAFEF00D, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 12, 5);
    @(negedge clk);
    check_val("rst_mask", busy_mask, 32'h0);
    check_val("rst_x12", rs1_data, 32'h0);
    check_val("rst_x5", rs2_data, 32'h0);
    check_val("rst_stall", {31'h0, stall}, 32'h0);
    step();

    // Randomized traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(63) == 0), 1'($urandom_range(1)), int'($urandom_range(15)),
            1'($urandom_range(1)), int'($urandom_range(15)), $urandom,
            int'($urandom_range(15)), int'($urandom_range(15)));
    end

    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
